fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Drain stage directly downstream of the 8-bit `fifo`. It pops one byte at a time through the FIFO's `rd`/`empty`/`d_out` interface and serialises it onto a UART line as 8N1, or 8E1 when parity is enabled. It runs on the FIFO's clock, so the FIFO plus this block form a buffered serial transmitter.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range is ≥ 2.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit between D7 and the stop bit.
- `clk`, input, 1: single clock; all state updates on posedge.
- `rst`, input, 1: synchronous, active-high reset.
- `fifo_empty`, input, 1: FIFO `empty` flag.
- `fifo_dout`, input, 8: FIFO `d_out`. It is registered in the FIFO and updates at the edge that samples `rd` high.
- `fifo_rd`, output, 1: registered, one-cycle pop strobe to the FIFO `rd`.
- `tx`, output, 1: serial line. Idle level is high.
- `busy`, output, 1: high whenever state ≠ IDLE.
- `tx_done`, output, 1: one-cycle pulse at the end of each stop bit.

## Operation
- **Interface contract:**
  - The FIFO honours `fifo_rd` whenever `fifo_empty` is low.
  - The system must not let a simultaneous write-while-full swallow the pop.
  - `fifo_empty` is only sampled in IDLE.
- **States:** IDLE, POP, WAIT, START, DATA, PARITY, STOP.
- **IDLE:** `tx`=1. If `fifo_empty`=0, go to POP and set `fifo_rd`=1. Otherwise stay.
- **POP:** `fifo_rd` is high for exactly this cycle; the FIFO samples it at the next edge. Go to WAIT and clear `fifo_rd`.
- **WAIT:** `fifo_dout` now holds the popped byte. At the edge leaving WAIT:
  - capture it into an 8-bit shift register;
  - compute parity = XOR of the 8 bits;
  - clear the baud counter and bit index;
  - go to START.
- **START:** `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA:**
  - `tx` = shift[0], LSB first.
  - After each CLKS_PER_BIT cycles, shift right and increment the 3-bit bit index.
  - After bit 7, go to PARITY if `PARITY_EN`=1, else STOP.
- **PARITY:** `tx` = stored parity (even: the total number of ones over data+parity is even), for CLKS_PER_BIT cycles.
- **STOP:**
  - `tx`=1 for CLKS_PER_BIT cycles.
  - `tx_done`=1 in the last cycle of STOP.
  - Then go to IDLE.
- **Baud counter:** width `$clog2(CLKS_PER_BIT)`. It counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary.
- **`tx` source:** driven from a register (no combinational glitches) and updated on the state-entry edge.
- **Empty FIFO:** stays in IDLE indefinitely. No `fifo_rd` pulses, `tx`=1, `busy`=0.
- **Reset mid-frame:**
  - the next edge forces IDLE, `tx`=1, `fifo_rd`=0, `busy`=0, `tx_done`=0;
  - the in-flight byte is discarded;
  - a `fifo_rd` asserted in the reset cycle is cleared at that same edge.

## Timing
- **Reset values:** `tx`=1, `fifo_rd`=0, `busy`=0, `tx_done`=0, state=IDLE, counters=0, shift register=0x00.
- **Pop sequence:** IDLE samples `fifo_empty`=0 at edge E0. Then:
  - `fifo_rd` is high in cycle E0..E1;
  - the FIFO `d_out` updates at E1;
  - the block captures at E2;
  - `tx` falls at E2.
- **Start latency:** 2 cycles from the IDLE sample edge to the start bit.
- **Frame length:** 10·CLKS_PER_BIT cycles with `PARITY_EN`=0; 11·CLKS_PER_BIT with `PARITY_EN`=1.
- **Back-to-back frames:** `tx` stays high for CLKS_PER_BIT (stop) + 3 cycles (IDLE, POP, WAIT) between frames. Throughput is one byte per 10·CLKS_PER_BIT+3 cycles.
- **Pop rate:** exactly one `fifo_rd` pulse per frame, never two within 10·CLKS_PER_BIT cycles.
- **`busy`:** rises at E0 and falls at the edge that enters IDLE (the same edge that ends `tx_done`).

## Test plan
- **Single byte, 8N1:** `CLKS_PER_BIT`=4, `PARITY_EN`=0. Load 0xA5 into the FIFO, then release.
  - `tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total).
  - One `fifo_rd` pulse, 2 cycles before `tx` falls.
  - `tx_done` pulses in the last stop cycle.
- **Back-to-back:** load 0x00 then 0xFF.
  - Two frames separated by exactly 4+3=7 high cycles.
  - Exactly two `fifo_rd` pulses.
  - `fifo_empty` is high after the second pop; afterwards `busy`=0 and `tx`=1 permanently.
- **Parity:** `PARITY_EN`=1, byte 0x07 → parity bit 1, 44-cycle frame. Byte 0x03 → parity bit 0.
- **Empty FIFO:** hold `fifo_empty`=1 for 200 cycles → `fifo_rd` never rises, `tx`=1, `busy`=0.
- **Reset mid-frame:** assert `rst` for 1 cycle during DATA bit 3 of 0x5A.
  - Next edge: `tx`=1, `busy`=0.
  - With a byte still queued, the following frame restarts cleanly with a full start bit.
  - The discarded byte is not re-sent.
- **Full FIFO drain:** fill all 8 entries 0x10..0x17, then stream.
  - 8 frames in order, LSB first.
  - 8 `fifo_rd` pulses.
  - Total time 8·43 − 3 cycles from first start bit to last stop end.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Drain stage placed directly after an 8-bit registered-output FIFO. It pops
// one byte at a time and serialises it onto a UART line as 8N1, or as 8E1
// when PARITY_EN is set. It shares the FIFO clock.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//   PARITY_EN    : 1 inserts an even-parity bit between D7 and the stop bit
// Ports
//   clk        : clock, all state updates on posedge
//   rst        : synchronous, active-high reset
//   fifo_empty : FIFO empty flag, sampled only while idle
//   fifo_dout  : FIFO read data, valid the cycle after the pop strobe
//   fifo_rd    : registered one-cycle pop strobe to the FIFO
//   tx         : serial line, idles high, registered
//   busy       : high whenever the engine is not idle
//   tx_done    : one-cycle pulse in the last cycle of the stop bit
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter bit PARITY_EN    = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_dout,
   output logic       fifo_rd,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_POP, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_q, par_d;
   logic             tx_q, tx_d;
   logic             rd_q, rd_d;
   logic             tx_done_q, tx_done_d;
   logic             bit_end;
   logic [CNT_W-1:0] cnt_next;

   // Even parity: the parity bit makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      par_d    = par_q;
      tx_d     = tx_q;
      rd_d     = 1'b0;
      bit_end  = (cnt_q == CNT_LAST);
      cnt_next = bit_end ? '0 : cnt_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               state_d = S_POP;
               rd_d    = 1'b1;
            end
         end
         S_POP: begin
            // The FIFO samples the strobe at the edge leaving this state.
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Read data is valid now; tx is driven low on the same edge.
            shift_d = fifo_dout;
            par_d   = even_parity(fifo_dout);
            cnt_d   = '0;
            idx_d   = '0;
            tx_d    = 1'b0;
            state_d = S_START;
         end
         S_START: begin
            cnt_d = cnt_next;
            if (bit_end) begin
               state_d = S_DATA;
               tx_d    = shift_q[0];
            end
         end
         S_DATA: begin
            cnt_d = cnt_next;
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  if (PARITY_EN) begin
                     state_d = S_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  // shift_q[1] becomes the LSB after this shift.
                  tx_d = shift_q[1];
               end
            end
         end
         S_PARITY: begin
            cnt_d = cnt_next;
            if (bit_end) begin
               state_d = S_STOP;
               tx_d    = 1'b1;
            end
         end
         S_STOP: begin
            cnt_d = cnt_next;
            if (bit_end) begin
               state_d = S_IDLE;
               tx_d    = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // Registered so the pulse lines up with the final stop cycle.
      tx_done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= 8'h00;
         par_q     <= 1'b0;
         tx_q      <= 1'b1;
         rd_q      <= 1'b0;
         tx_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         tx_q      <= tx_d;
         rd_q      <= rd_d;
         tx_done_q <= tx_done_d;
      end
   end

   assign fifo_rd = rd_q;
   assign tx      = tx_q;
   assign tx_done = tx_done_q;
   assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
// Two instances of fifo_uart_tx with CLKS_PER_BIT=4: lane 0 without parity,
// lane 1 with even parity. Each lane is fed by a small behavioural FIFO with
// a registered read port. Bytes are pushed into the FIFO and into a
// scoreboard together; a frame receiver decodes the tx line and compares
// the decoded byte with the scoreboard head.
module tb_fifo_uart_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] empty_w;
   logic [1:0] rd_w, tx_w, busy_w, done_w;
   logic [7:0] dout0 = 8'h00;
   logic [7:0] dout1 = 8'h00;
   logic       empty0 = 1'b1;
   logic       empty1 = 1'b1;

   logic [7:0] fq0[$];
   logic [7:0] fq1[$];
   logic [7:0] exp_q[$];

   int n_chk = 0;
   int n_bad = 0;
   int cyc   = 0;
   int rd_cnt [2];
   int last_rd_cyc [2];
   bit rd_prev_ok [2];
   int spacing_err = 0;
   int last_fall = 0;
   int last_end  = 0;

   always #5 clk = ~clk;

   assign empty_w = {empty1, empty0};

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
      .clk(clk), .rst(rst), .fifo_empty(empty_w[0]), .fifo_dout(dout0),
      .fifo_rd(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0])
   );

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
      .clk(clk), .rst(rst), .fifo_empty(empty_w[1]), .fifo_dout(dout1),
      .fifo_rd(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1])
   );

   // Behavioural FIFOs: d_out and empty update at the edge that samples rd.
   always @(posedge clk) begin
      if (rd_w[0] && fq0.size() != 0) begin
         dout0 <= fq0[0];
         void'(fq0.pop_front());
      end
      empty0 <= (fq0.size() == 0);
   end

   always @(posedge clk) begin
      if (rd_w[1] && fq1.size() != 0) begin
         dout1 <= fq1[0];
         void'(fq1.pop_front());
      end
      empty1 <= (fq1.size() == 0);
   end

   // Cycle counter and pop-strobe monitor (values seen here are pre-edge).
   initial begin
      for (int i = 0; i < 2; i++) begin
         rd_cnt[i] = 0;
         last_rd_cyc[i] = 0;
         rd_prev_ok[i] = 1'b0;
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rd_w[i]) begin
            if (rd_prev_ok[i] && (cyc - last_rd_cyc[i]) < 10 * CPB)
               spacing_err <= spacing_err + 1;
            last_rd_cyc[i] <= cyc;
            rd_cnt[i]      <= rd_cnt[i] + 1;
         end
         rd_prev_ok[i] <= rst ? 1'b0 : (rd_w[i] ? 1'b1 : rd_prev_ok[i]);
      end
      cyc <= cyc + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic push_byte(input int lane, input logic [7:0] b);
      if (lane == 0) fq0.push_back(b);
      else           fq1.push_back(b);
      exp_q.push_back(b);
   endtask

   // Decode one frame on the given lane and compare against the scoreboard.
   task automatic rx_frame(input int lane);
      int         n = 0;
      int         nb;
      int         hold_err = 0;
      int         done_err = 0;
      int         busy_err = 0;
      logic [10:0] bits = '0;
      logic       v;
      logic [7:0] exp_b;
      nb = (lane == 1) ? 11 : 10;
      @(negedge clk);
      while (tx_w[lane] !== 1'b0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (tx_w[lane] !== 1'b0) begin
         check_eq("rx_timeout", 32'd1, 32'd0);
         return;
      end
      last_fall = cyc;
      check_eq("rd_lead", cyc - last_rd_cyc[lane], 32'd2);
      for (int b = 0; b < nb; b++) begin
         for (int c = 0; c < CPB; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            v = tx_w[lane];
            if (c == 0) bits[b] = v;
            else if (v !== bits[b]) hold_err++;
            if (done_w[lane] !== ((b == nb - 1) && (c == CPB - 1))) done_err++;
            if (busy_w[lane] !== 1'b1) busy_err++;
         end
      end
      last_end = cyc;
      if (exp_q.size() == 0) begin
         check_eq("sb_empty", 32'd1, 32'd0);
         exp_b = 8'h00;
      end else begin
         exp_b = exp_q.pop_front();
      end
      check_eq("bit_hold", hold_err, 0);
      check_eq("done_pos", done_err, 0);
      check_eq("busy_frame", busy_err, 0);
      check_eq("data_byte", bits[8:1], exp_b);
      if (lane == 1) check_eq("parity_bit", bits[9], ^exp_b);
      check_eq("stop_bit", bits[nb-1], 1'b1);
      @(negedge clk);
      check_eq("idle_after", {busy_w[lane], tx_w[lane], done_w[lane]}, 3'b010);
   endtask

   initial begin
      int r0, r1, e1, first_fall, errs, n;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, e1, first_fall, errs, n;

      // Reset values
      repeat (3) @(negedge clk);
      check_eq("rst_tx", tx_w, 2'b11);
      check_eq("rst_rd", rd_w, 2'b00);
      check_eq("rst_busy", busy_w, 2'b00);
      check_eq("rst_done", done_w, 2'b00);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Empty FIFO: nothing happens for 200 cycles
      r0 = rd_cnt[0] + rd_cnt[1];
      errs = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tx_w !== 2'b11) errs++;
         if (busy_w !== 2'b00) errs++;
      end
      check_eq("empty_idle", errs, 0);
      check_eq("empty_rd", rd_cnt[0] + rd_cnt[1] - r0, 0);

      // Single byte, 8N1
      r0 = rd_cnt[0];
      push_byte(0, 8'hA5);
      rx_frame(0);
      check_eq("single_len", last_end - last_fall + 1, 10 * CPB);
      check_eq("single_rd", rd_cnt[0] - r0, 1);

      // Back-to-back 0x00 then 0xFF
      r0 = rd_cnt[0];
      push_byte(0, 8'h00);
      push_byte(0, 8'hFF);
      rx_frame(0);
      e1 = last_end;
      rx_frame(0);
      check_eq("b2b_high", last_fall - e1 - 1 + CPB, CPB + 3);
      check_eq("b2b_rd", rd_cnt[0] - r0, 2);
      check_eq("b2b_empty", empty_w[0], 1'b1);
      errs = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1) errs++;
      end
      check_eq("b2b_quiet", errs, 0);

      // Parity lane: 0x07 and 0x03
      r0 = rd_cnt[1];
      push_byte(1, 8'h07);
      rx_frame(1);
      check_eq("par_len", last_end - last_fall + 1, 11 * CPB);
      push_byte(1, 8'h03);
      rx_frame(1);
      check_eq("par_rd", rd_cnt[1] - r0, 2);

      // Reset during DATA bit 3 of 0x5A with 0x3C still queued
      r0 = rd_cnt[0];
      push_byte(0, 8'h5A);
      push_byte(0, 8'h3C);
      n = 0;
      @(negedge clk);
      while (tx_w[0] !== 1'b0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check_eq("rst_frame_start", tx_w[0], 1'b0);
      repeat (4 * CPB + 1) @(negedge clk);
      check_eq("rst_bit3", tx_w[0], 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("midrst_state", {tx_w[0], busy_w[0], rd_w[0], done_w[0]}, 4'b1000);
      void'(exp_q.pop_front());
      rx_frame(0);
      errs = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (busy_w[0] !== 1'b0) errs++;
      end
      check_eq("midrst_noresend", errs, 0);
      check_eq("midrst_rd", rd_cnt[0] - r0, 2);

      // Full drain of 8 entries
      r0 = rd_cnt[0];
      for (int i = 0; i < 8; i++) push_byte(0, 8'h10 + 8'(i));
      rx_frame(0);
      first_fall = last_fall;
      for (int i = 1; i < 8; i++) rx_frame(0);
      check_eq("drain_len", last_end - first_fall + 1, 8 * (10 * CPB + 3) - 3);
      check_eq("drain_rd", rd_cnt[0] - r0, 8);
      check_eq("sb_left", exp_q.size(), 0);
      check_eq("rd_spacing", spacing_err, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
